// File: rtl/hamming_mem_engine_if.sv
// Bus bundle between the Hamming engine and its host / data-memory byte port.
// The engine side takes the master modport (it drives the memory address and
// write strobe); the host side, which owns the memory and start/mode, takes slave.
interface hamming_mem_engine_if #(
    parameter int unsigned AW = 8
) ();
    logic          start;
    logic          mode;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;
    logic          busy;
    logic          done;
    logic [6:0]    n_single;
    logic [6:0]    n_double;

    modport master (
        input  start,
        input  mode,
        input  mem_rd_data,
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data,
        output busy,
        output done,
        output n_single,
        output n_double
    );

    modport slave (
        output start,
        output mode,
        output mem_rd_data,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data,
        input  busy,
        input  done,
        input  n_single,
        input  n_double
    );
endinterface

// File: rtl/hamming_mem_engine.sv
// SEC-DED Hamming(16,11) memory engine.
// Walks NUM_MSG two-byte records starting at SRC_BASE, encodes (mode=0) or
// decodes/corrects (mode=1) each one, and writes the result to DST_BASE.
// Every record takes five cycles: read lo, read hi, compute, write lo, write hi.
module hamming_mem_engine #(
    parameter int unsigned NUM_MSG  = 15,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 30,
    parameter int unsigned AW       = 8
) (
    input logic                  clk,
    input logic                  reset,
    hamming_mem_engine_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StCalc,
        StWrLo,
        StWrHi,
        StDone
    } state_e;

    localparam logic [6:0] LastIdx = 7'(NUM_MSG - 1);
    localparam logic [6:0] CntMax  = 7'd127;

    // Parity-group masks: bit k is set when Hamming position k belongs to the group.
    localparam logic [15:0] MaskP1 = 16'hAAAA;
    localparam logic [15:0] MaskP2 = 16'hCCCC;
    localparam logic [15:0] MaskP4 = 16'hF0F0;
    localparam logic [15:0] MaskP8 = 16'hFF00;

    state_e        state_q, state_d;
    logic [6:0]    idx_q, idx_d;
    logic          mode_q, mode_d;
    logic [7:0]    lo_q, lo_d;
    logic [7:0]    hi_q, hi_d;
    logic [15:0]   res_q, res_d;
    logic [6:0]    n_single_q, n_single_d;
    logic [6:0]    n_double_q, n_double_d;

    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW-1:0] addr_out;
    logic          wr_en_out;
    logic [7:0]    wr_data_out;

    // Codeword layout {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
    // Parity bits are still zero while their group is summed, so each group
    // parity only covers data bits and previously cleared parity slots.
    function automatic logic [15:0] hamming_encode(input logic [10:0] d);
        logic [15:0] cw;
        cw    = {d[10:4], 1'b0, d[3:1], 1'b0, d[0], 3'b000};
        cw[1] = ^(cw & MaskP1);
        cw[2] = ^(cw & MaskP2);
        cw[4] = ^(cw & MaskP4);
        cw[8] = ^(cw & MaskP8);
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    // Returns the destination word {F1, F0, 3'b0, d11..d9, d8..d1}.
    // Overall parity set means a single error at position s (s=0 is p0 itself);
    // a non-zero syndrome with clean overall parity is an uncorrectable double.
    function automatic logic [15:0] hamming_decode(input logic [15:0] cw_in);
        logic [3:0]  syn;
        logic        par;
        logic [1:0]  flags;
        logic [15:0] cw;
        syn = {^(cw_in & MaskP8), ^(cw_in & MaskP4), ^(cw_in & MaskP2), ^(cw_in & MaskP1)};
        par = ^cw_in;
        cw  = cw_in;
        if (par) begin
            flags = 2'b01;
            cw    = cw_in ^ (16'h0001 << syn);
        end else if (syn != 4'd0) begin
            flags = 2'b10;
        end else begin
            flags = 2'b00;
        end
        return {flags, 3'b000, cw[15:13], cw[12:9], cw[7:5], cw[3]};
    endfunction

    assign src_addr = AW'(SRC_BASE) + AW'({idx_q, 1'b0});
    assign dst_addr = AW'(DST_BASE) + AW'({idx_q, 1'b0});

    // State and datapath registers; reset returns to IDLE with everything cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= 7'd0;
            mode_q     <= 1'b0;
            lo_q       <= 8'd0;
            hi_q       <= 8'd0;
            res_q      <= 16'd0;
            n_single_q <= 7'd0;
            n_double_q <= 7'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mode_q     <= mode_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            res_q      <= res_d;
            n_single_q <= n_single_d;
            n_double_q <= n_double_d;
        end
    end

    // Next-state: record walk, byte capture, result compute and error counting.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        res_d      = res_q;
        n_single_d = n_single_q;
        n_double_d = n_double_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    idx_d      = 7'd0;
                    n_single_d = 7'd0;
                    n_double_d = 7'd0;
                    mode_d     = bus.mode;
                    state_d    = StRdLo;
                end
            end
            StRdLo: begin
                lo_d    = bus.mem_rd_data;
                state_d = StRdHi;
            end
            StRdHi: begin
                hi_d    = bus.mem_rd_data;
                state_d = StCalc;
            end
            StCalc: begin
                if (mode_q) begin
                    res_d = hamming_decode({hi_q, lo_q});
                    if (res_d[15:14] == 2'b01 && n_single_q != CntMax) begin
                        n_single_d = n_single_q + 7'd1;
                    end
                    if (res_d[15:14] == 2'b10 && n_double_q != CntMax) begin
                        n_double_d = n_double_q + 7'd1;
                    end
                end else begin
                    // Upper five bits of the source hi byte are not part of the message.
                    res_d = hamming_encode({hi_q[2:0], lo_q});
                end
                state_d = StWrLo;
            end
            StWrLo: begin
                state_d = StWrHi;
            end
            StWrHi: begin
                if (idx_q < LastIdx) begin
                    idx_d   = idx_q + 7'd1;
                    state_d = StRdLo;
                end else begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Memory port drive: source address while reading, destination plus strobe while writing.
    always_comb begin
        addr_out    = '0;
        wr_en_out   = 1'b0;
        wr_data_out = 8'd0;
        unique case (state_q)
            StRdLo: addr_out = src_addr;
            StRdHi: addr_out = src_addr + AW'(1);
            StWrLo: begin
                addr_out    = dst_addr;
                wr_en_out   = 1'b1;
                wr_data_out = res_q[7:0];
            end
            StWrHi: begin
                addr_out    = dst_addr + AW'(1);
                wr_en_out   = 1'b1;
                wr_data_out = res_q[15:8];
            end
            default: begin
                addr_out    = '0;
                wr_en_out   = 1'b0;
                wr_data_out = 8'd0;
            end
        endcase
    end

    assign bus.mem_addr    = addr_out;
    assign bus.mem_wr_en   = wr_en_out;
    assign bus.mem_wr_data = wr_data_out;
    assign bus.busy        = (state_q != StIdle) && (state_q != StDone);
    assign bus.done        = (state_q == StDone);
    assign bus.n_single    = n_single_q;
    assign bus.n_double    = n_double_q;

endmodule

// File: tb/tb_hamming_mem_engine.sv
// Scoreboard bench for hamming_mem_engine: each pass loads source records,
// pushes the expected destination writes, and a negedge monitor pops and
// compares every write the engine issues.
module tb_hamming_mem_engine;

    localparam int NUM = 15;
    localparam int DST = 30;

    logic clk;
    logic reset;

    hamming_mem_engine_if #(.AW(8)) bus ();

    hamming_mem_engine #(
        .NUM_MSG  (NUM),
        .SRC_BASE (0),
        .DST_BASE (DST),
        .AW       (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0]  src_mem [256];
    logic [7:0]  dst_mem [256];
    logic [15:0] rec_word [NUM];
    logic [15:0] exp_dst [NUM];
    logic [15:0] exp_q [$];
    logic [15:0] mon_w;
    int          exp_single;
    int          exp_double;
    int          total = 0;
    int          bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rd_data = src_mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_wr_en) dst_mem[bus.mem_addr] <= bus.mem_wr_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference encoder: data bits fill the non-power-of-two positions in order;
    // parity bits take the syndrome of the data-only word.
    function automatic logic [15:0] ref_encode(input logic [10:0] d);
        logic [15:0] cw;
        logic [3:0]  s;
        int          j;
        cw = '0;
        s  = '0;
        j  = 0;
        for (int k = 1; k < 16; k++) begin
            if ((k & (k - 1)) != 0) begin
                cw[k[3:0]] = d[j[3:0]];
                j++;
            end
        end
        for (int k = 1; k < 16; k++) begin
            if (cw[k[3:0]]) s = s ^ k[3:0];
        end
        cw[1] = s[0];
        cw[2] = s[1];
        cw[4] = s[2];
        cw[8] = s[3];
        for (int k = 1; k < 16; k++) cw[0] = cw[0] ^ cw[k[3:0]];
        return cw;
    endfunction

    function automatic logic [15:0] ref_decode(input logic [15:0] cw_in);
        logic [15:0] cw;
        logic [3:0]  s;
        logic        p;
        logic [1:0]  f;
        logic [10:0] d;
        int          j;
        cw = cw_in;
        s  = '0;
        p  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (cw[k[3:0]]) begin
                p = ~p;
                s = s ^ k[3:0];
            end
        end
        if (p) begin
            f = 2'b01;
            cw[s] = ~cw[s];
        end else if (s != 0) begin
            f = 2'b10;
        end else begin
            f = 2'b00;
        end
        d = '0;
        j = 0;
        for (int k = 1; k < 16; k++) begin
            if ((k & (k - 1)) != 0) begin
                d[j[3:0]] = cw[k[3:0]];
                j++;
            end
        end
        return {f, 3'b000, d[10:8], d[7:0]};
    endfunction

    task automatic load_pass(input logic m);
        logic [15:0] r;
        logic [7:0]  a;
        exp_single = 0;
        exp_double = 0;
        for (int i = 0; i < NUM; i++) begin
            a = 8'(2 * i);
            src_mem[a]        = rec_word[i][7:0];
            src_mem[a + 8'd1] = rec_word[i][15:8];
            if (m) r = ref_decode(rec_word[i]);
            else   r = ref_encode(rec_word[i][10:0]);
            if (m && r[15:14] == 2'b01 && exp_single < 127) exp_single++;
            if (m && r[15:14] == 2'b10 && exp_double < 127) exp_double++;
            exp_dst[i] = r;
            a = 8'(DST + 2 * i);
            exp_q.push_back({a, r[7:0]});
            exp_q.push_back({a + 8'd1, r[15:8]});
        end
    endtask

    task automatic start_pass(input logic m);
        @(negedge clk);
        bus.mode  = m;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq("start_busy", 32'(bus.busy), 32'd1);
        check_eq("start_done_low", 32'(bus.done), 32'd0);
        check_eq("start_single_clr", 32'(bus.n_single), 32'd0);
        check_eq("start_double_clr", 32'(bus.n_double), 32'd0);
    endtask

    // Counts edges after the accepting edge until done; optionally pulses start
    // (with the opposite mode) while busy to confirm it is ignored.
    task automatic wait_done(input logic m, input int poke_at, output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == poke_at) begin
                bus.start = 1'b1;
                bus.mode  = ~m;
            end else if (cyc == poke_at + 1) begin
                bus.start = 1'b0;
                bus.mode  = m;
            end
        end
        check_eq("done_seen", 32'(bus.done), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
        check_eq({tag, "_wren"}, 32'(bus.mem_wr_en), 32'd0);
        check_eq({tag, "_wdata"}, 32'(bus.mem_wr_data), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_single"}, 32'(bus.n_single), 32'd0);
        check_eq({tag, "_double"}, 32'(bus.n_double), 32'd0);
    endtask

    // Every write must be expected, in order, at the right address with the right byte.
    always @(negedge clk) begin
        if (bus.mem_wr_en) begin
            check_eq("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_w = exp_q.pop_front();
                check_eq("wr_addr", 32'(bus.mem_addr), 32'(mon_w[15:8]));
                check_eq("wr_data", 32'(bus.mem_wr_data), 32'(mon_w[7:0]));
            end
        end
    end

    initial begin
        int          cyc;
        int          n;
        logic        found;
        logic [15:0] cw;
        logic [3:0]  b1;
        logic [3:0]  b2;
        logic [7:0]  prev_lo3;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        for (int i = 0; i < 256; i++) src_mem[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Pass A: encode, fixed vectors plus random records with junk upper bits.
        rec_word[0] = 16'h0000;
        rec_word[1] = 16'h07FF;
        rec_word[2] = 16'h0001;
        for (int i = 3; i < NUM; i++) rec_word[i] = 16'($urandom);
        load_pass(1'b0);
        start_pass(1'b0);
        wait_done(1'b0, 0, cyc);
        check_eq("enc_done_cycles", 32'(cyc), 32'd75);
        check_eq("enc_all_written", 32'(exp_q.size()), 32'd0);
        check_eq("enc_zero_lo", 32'(dst_mem[30]), 32'h00);
        check_eq("enc_zero_hi", 32'(dst_mem[31]), 32'h00);
        check_eq("enc_ones_lo", 32'(dst_mem[32]), 32'hFF);
        check_eq("enc_ones_hi", 32'(dst_mem[33]), 32'hFF);
        check_eq("enc_one_lo", 32'(dst_mem[34]), 32'h0F);
        check_eq("enc_one_hi", 32'(dst_mem[35]), 32'h00);
        check_eq("enc_single", 32'(bus.n_single), 32'd0);
        check_eq("enc_double", 32'(bus.n_double), 32'd0);

        // Pass B: decode with 0/1/2 bit errors; a start pulse mid-run must be ignored.
        rec_word[0] = 16'h002F;
        rec_word[1] = 16'h000E;
        rec_word[2] = 16'h006F;
        for (int i = 3; i < NUM; i++) begin
            cw = ref_encode(11'($urandom));
            b1 = 4'($urandom_range(0, 15));
            b2 = b1 + 4'($urandom_range(1, 15));
            n  = int'($urandom_range(0, 2));
            if (n >= 1) cw[b1] = ~cw[b1];
            if (n == 2) cw[b2] = ~cw[b2];
            rec_word[i] = cw;
        end
        load_pass(1'b1);
        start_pass(1'b1);
        wait_done(1'b1, 20, cyc);
        check_eq("dec_done_cycles", 32'(cyc), 32'd75);
        check_eq("dec_all_written", 32'(exp_q.size()), 32'd0);
        check_eq("dec_bit5_lo", 32'(dst_mem[30]), 32'h01);
        check_eq("dec_bit5_hi", 32'(dst_mem[31]), 32'h40);
        check_eq("dec_p0_lo", 32'(dst_mem[32]), 32'h01);
        check_eq("dec_p0_hi", 32'(dst_mem[33]), 32'h40);
        check_eq("dec_dbl_lo", 32'(dst_mem[34]), 32'h07);
        check_eq("dec_dbl_hi", 32'(dst_mem[35]), 32'h80);
        check_eq("dec_single", 32'(bus.n_single), 32'(exp_single));
        check_eq("dec_double", 32'(bus.n_double), 32'(exp_double));
        repeat (2) @(posedge clk);
        #1;
        check_eq("done_hold", 32'(bus.done), 32'd1);
        check_eq("done_hold_single", 32'(bus.n_single), 32'(exp_single));

        // Pass C: restart from DONE (counters must clear), one double error only.
        rec_word[0] = 16'h006F;
        for (int i = 1; i < NUM; i++) rec_word[i] = ref_encode(11'($urandom));
        load_pass(1'b1);
        start_pass(1'b1);
        wait_done(1'b1, 0, cyc);
        check_eq("dbl_done_cycles", 32'(cyc), 32'd75);
        check_eq("dbl_all_written", 32'(exp_q.size()), 32'd0);
        check_eq("dbl_n_double", 32'(bus.n_double), 32'd1);
        check_eq("dbl_n_single", 32'(bus.n_single), 32'd0);

        // Pass D: reset during WR_LO of record 3.
        prev_lo3 = exp_dst[3][7:0];
        for (int i = 0; i < NUM; i++) rec_word[i] = 16'($urandom);
        rec_word[3][7:0] = ~ref_encode(rec_word[3][10:0]) >> 8;
        load_pass(1'b0);
        start_pass(1'b0);
        found = 1'b0;
        n     = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.mem_wr_en && bus.mem_addr == 8'(DST + 6)) found = 1'b1;
        end
        check_eq("rst_wrlo_seen", 32'(found), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst_busy_now", 32'(bus.busy), 32'd0);
        check_eq("rst_done_now", 32'(bus.done), 32'd0);
        check_eq("rst_wren_now", 32'(bus.mem_wr_en), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("post_rst");
        check_eq("rst_rec3_unwritten", 32'(dst_mem[8'(DST + 6)]), 32'(prev_lo3));
        check_eq("rst_rec2_kept", 32'(dst_mem[8'(DST + 5)]), 32'(exp_dst[2][15:8]));

        // Pass E: clean full pass after reset.
        for (int i = 0; i < NUM; i++) rec_word[i] = 16'($urandom);
        load_pass(1'b0);
        start_pass(1'b0);
        wait_done(1'b0, 0, cyc);
        check_eq("clean_done_cycles", 32'(cyc), 32'd75);
        check_eq("clean_all_written", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
